// File: rtl/spmv_x_fetch.sv
// spmv_x_fetch: x-vector gather stage of an SpMV pipeline.
// Takes beats of PARALLELISM (column, matrix value) lanes, issues one vector-RAM read per
// beat, parks {aval, mask, last} in a side FIFO, and pairs each in-order RAM response with
// its FIFO entry in a registered output stage.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   s_valid_i/s_ready_o, s_col_i, s_aval_i, s_mask_i, s_last_i   input beat
//   vr_arvalid_o/vr_arready_i, vr_raddr_o                       RAM read request
//   vr_rvalid_i/vr_rready_o, vr_rdata_i                         RAM read response
//   o_valid_o/o_ready_i, o_aval_o, o_xval_o, o_mask_o, o_last_o paired output
//   done_o                                                      end-of-block pulse
//
// Optional: define SPMV_X_FETCH_STATS_EN to add stat_beats_o (issued beats) and
// stat_stall_o (cycles with s_valid_i && !s_ready_o), both 32-bit saturating.
module spmv_x_fetch #(
    parameter int unsigned PARALLELISM     = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              s_valid_i,
    output logic                              s_ready_o,
    input  logic [PARALLELISM*ADDR_WIDTH-1:0] s_col_i,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] s_aval_i,
    input  logic [PARALLELISM-1:0]            s_mask_i,
    input  logic                              s_last_i,
    output logic                              vr_arvalid_o,
    input  logic                              vr_arready_i,
    output logic [PARALLELISM*ADDR_WIDTH-1:0] vr_raddr_o,
    input  logic                              vr_rvalid_i,
    output logic                              vr_rready_o,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] vr_rdata_i,
    output logic                              o_valid_o,
    input  logic                              o_ready_i,
    output logic [PARALLELISM*DATA_WIDTH-1:0] o_aval_o,
    output logic [PARALLELISM*DATA_WIDTH-1:0] o_xval_o,
    output logic [PARALLELISM-1:0]            o_mask_o,
    output logic                              o_last_o,
    output logic                              done_o
`ifdef SPMV_X_FETCH_STATS_EN
    ,
    output logic [31:0]                       stat_beats_o,
    output logic [31:0]                       stat_stall_o
`endif
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned DW   = PARALLELISM * DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                 state_q;
    logic                   en_q;
    logic                   err_q;
    // Every issued beat owns exactly one side-FIFO slot until its response returns, so one
    // counter serves as both the read-credit count and the FIFO occupancy.
    logic [CntW-1:0]        cnt_q;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]          fifo_aval_q [MAX_OUTSTANDING];
    logic [PARALLELISM-1:0] fifo_mask_q [MAX_OUTSTANDING];
    logic                   fifo_last_q [MAX_OUTSTANDING];

    logic                   o_valid_q, o_last_q;
    logic [DW-1:0]          o_aval_q, o_xval_q, xval_d;
    logic [PARALLELISM-1:0] o_mask_q;

    logic can_take, issue, resp_hs, pop, fifo_empty, out_free;

    // en_q keeps all handshakes low while reset is held and for the first clock after release.
    assign can_take     = en_q && (cnt_q < CntW'(MAX_OUTSTANDING)) && (state_q != StDrain);
    assign vr_arvalid_o = s_valid_i && can_take;
    assign s_ready_o    = vr_arready_i && can_take;
    assign issue        = vr_arvalid_o && vr_arready_i;

    assign fifo_empty  = (cnt_q == '0);
    assign out_free    = !o_valid_q || o_ready_i;
    assign vr_rready_o = en_q && out_free;
    assign resp_hs     = vr_rvalid_i && vr_rready_o;
    // A response with nothing outstanding is dropped and only flagged.
    assign pop         = resp_hs && !fifo_empty;

    assign done_o = (state_q == StDrain) && fifo_empty && !o_valid_q;

    always_comb begin
        vr_raddr_o = '0;
        xval_d     = '0;
        for (int i = 0; i < int'(PARALLELISM); i++) begin
            if (en_q && s_mask_i[i]) begin
                vr_raddr_o[i*ADDR_WIDTH +: ADDR_WIDTH] = s_col_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (fifo_mask_q[rd_ptr_q][i]) begin
                xval_d[i*DATA_WIDTH +: DATA_WIDTH] = vr_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Side FIFO storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            fifo_aval_q[wr_ptr_q] <= s_aval_i;
            fifo_mask_q[wr_ptr_q] <= s_mask_i;
            fifo_last_q[wr_ptr_q] <= s_last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            o_valid_q <= 1'b0;
            o_aval_q  <= '0;
            o_xval_q  <= '0;
            o_mask_q  <= '0;
            o_last_q  <= 1'b0;
        end else begin
            en_q <= 1'b1;

            if (resp_hs && fifo_empty) begin
                err_q <= 1'b1;
            end

            unique case ({issue, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase

            if (issue) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end

            if (pop) begin
                rd_ptr_q  <= (rd_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PtrW'(1);
                o_valid_q <= 1'b1;
                o_aval_q  <= fifo_aval_q[rd_ptr_q];
                o_xval_q  <= xval_d;
                o_mask_q  <= fifo_mask_q[rd_ptr_q];
                o_last_q  <= fifo_last_q[rd_ptr_q];
            end else if (o_ready_i) begin
                o_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        state_q <= s_last_i ? StDrain : StRun;
                    end
                end
                StRun: begin
                    if (issue && s_last_i) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (done_o) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_valid_o = o_valid_q;
    assign o_aval_o  = o_aval_q;
    assign o_xval_o  = o_xval_q;
    assign o_mask_o  = o_mask_q;
    assign o_last_o  = o_last_q;

`ifdef SPMV_X_FETCH_STATS_EN
    logic [31:0] stat_beats_q, stat_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (issue && (stat_beats_q != '1)) begin
                stat_beats_q <= stat_beats_q + 32'd1;
            end
            if (s_valid_i && !s_ready_o && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_beats_o = stat_beats_q;
    assign stat_stall_o = stat_stall_q;
`endif

`ifndef SYNTHESIS
    // Stray response (nothing outstanding) seen on an earlier cycle.
    a_no_stray_resp: assert property (@(posedge clk_i) disable iff (!rst_ni) !err_q);
`endif

endmodule

// File: tb/tb_spmv_x_fetch.sv
// tb_spmv_x_fetch: directed bench for spmv_x_fetch (PARALLELISM=4, 32-bit data, 16-bit
// columns, 8 credits). The bench plays the vector RAM with x[c] = 10*c and a 2-cycle
// response delay; single-beat blocks come from a hand-computed table, multi-cycle corner
// cases are hand-written sequences checked against an in-order scoreboard.
module tb_spmv_x_fetch;

    localparam int P  = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid, s_ready, s_last;
    logic [P*AW-1:0] s_col;
    logic [P*DW-1:0] s_aval;
    logic [P-1:0]    s_mask;
    logic            vr_arvalid, vr_arready;
    logic [P*AW-1:0] vr_raddr;
    logic            vr_rvalid, vr_rready;
    logic [P*DW-1:0] vr_rdata;
    logic            o_valid, o_ready, o_last, done;
    logic [P*DW-1:0] o_aval, o_xval;
    logic [P-1:0]    o_mask;
`ifdef SPMV_X_FETCH_STATS_EN
    logic [31:0]     stat_beats, stat_stall;
`endif

    always #5 clk = ~clk;

    spmv_x_fetch #(
        .PARALLELISM    (P),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_col_i     (s_col),
        .s_aval_i    (s_aval),
        .s_mask_i    (s_mask),
        .s_last_i    (s_last),
        .vr_arvalid_o(vr_arvalid),
        .vr_arready_i(vr_arready),
        .vr_raddr_o  (vr_raddr),
        .vr_rvalid_i (vr_rvalid),
        .vr_rready_o (vr_rready),
        .vr_rdata_i  (vr_rdata),
        .o_valid_o   (o_valid),
        .o_ready_i   (o_ready),
        .o_aval_o    (o_aval),
        .o_xval_o    (o_xval),
        .o_mask_o    (o_mask),
        .o_last_o    (o_last),
`ifdef SPMV_X_FETCH_STATS_EN
        .stat_beats_o(stat_beats),
        .stat_stall_o(stat_stall),
`endif
        .done_o      (done)
    );

    typedef struct {
        logic [63:0]  col;
        logic [127:0] aval;
        logic [3:0]   mask;
        logic [63:0]  raddr;
        logic [127:0] xval;
    } vec_t;

    typedef struct {
        logic [127:0] aval;
        logic [127:0] xval;
        logic [3:0]   mask;
        logic         last;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    vec_t  vecs [5];
    req_t  req_q [$];
    beat_t exp_q [$];
    beat_t out_q [$];
    int    n_chk = 0, n_pass = 0, cyc = 0, n_issued = 0, n_done = 0;
    bit    ram_hold = 1'b0;

    function automatic logic [127:0] xmodel(input logic [63:0] col, input logic [3:0] mask);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < P; l++) begin
            if (mask[l]) r[l*DW +: DW] = 32'(col[l*AW +: AW]) * 32'd10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic ram_drive();
        if (!ram_hold && req_q.size() > 0 && req_q[0].due <= cyc) begin
            vr_rvalid = 1'b1;
            for (int l = 0; l < P; l++) begin
                vr_rdata[l*DW +: DW] = 32'(req_q[0].addr[l*AW +: AW]) * 32'd10;
            end
        end else begin
            vr_rvalid = 1'b0;
            vr_rdata  = '0;
        end
    endtask

    // Observe every handshake at the falling edge, before the rising edge commits it.
    task automatic sample();
        @(negedge clk);
        if (vr_rvalid && vr_rready && req_q.size() > 0) req_q.delete(0);
        if (vr_arvalid && vr_arready) begin
            req_t r;
            r.addr = vr_raddr;
            r.due  = cyc + 2;
            req_q.push_back(r);
            n_issued++;
        end
        if (s_valid && s_ready) begin
            beat_t b;
            b.aval = s_aval;
            b.mask = s_mask;
            b.last = s_last;
            b.xval = xmodel(s_col, s_mask);
            exp_q.push_back(b);
        end
        if (o_valid && o_ready) begin
            beat_t b;
            b.aval = o_aval;
            b.xval = o_xval;
            b.mask = o_mask;
            b.last = o_last;
            out_q.push_back(b);
        end
        if (done) n_done++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        ram_drive();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            adv();
        end
    endtask

    task automatic drive_beat(input int k, input bit last);
        s_valid = 1'b1;
        s_mask  = 4'hF;
        s_last  = last;
        for (int l = 0; l < P; l++) begin
            s_col[l*AW +: AW]  = 16'(k * 4 + l + 1);
            s_aval[l*DW +: DW] = 32'(k * 100 + l);
        end
    endtask

    task automatic cmp_sb(input string name);
        chk({name, "_count"}, 128'(out_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_aval%0d", name, i), out_q[i].aval, exp_q[i].aval);
            chk($sformatf("%s_xval%0d", name, i), out_q[i].xval, exp_q[i].xval);
            chk($sformatf("%s_mask%0d", name, i), 128'(out_q[i].mask), 128'(exp_q[i].mask));
            chk($sformatf("%s_last%0d", name, i), 128'(out_q[i].last), 128'(exp_q[i].last));
        end
        out_q.delete();
        exp_q.delete();
    endtask

    // One-beat block (s_last=1) through the 2-cycle RAM with o_ready held high.
    task automatic run_vec(input int k);
        vec_t v;
        bit   got;
        v      = vecs[k];
        n_done = 0;
        got    = 1'b0;
        s_valid = 1'b1;
        s_col   = v.col;
        s_aval  = v.aval;
        s_mask  = v.mask;
        s_last  = 1'b1;
        o_ready = 1'b1;
        sample();
        chk($sformatf("vec%0d_raddr", k), vr_raddr, v.raddr);
        chk($sformatf("vec%0d_arvalid", k), vr_arvalid, 1);
        chk($sformatf("vec%0d_s_ready", k), s_ready, 1);
        adv();
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            sample();
            if (o_valid) got = 1'b1;
            else adv();
        end
        chk($sformatf("vec%0d_o_valid", k), got, 1);
        chk($sformatf("vec%0d_xval", k), o_xval, v.xval);
        chk($sformatf("vec%0d_aval", k), o_aval, v.aval);
        chk($sformatf("vec%0d_mask", k), o_mask, v.mask);
        chk($sformatf("vec%0d_last", k), o_last, 1);
        chk($sformatf("vec%0d_done_early", k), done, 0);
        adv();
        sample();
        chk($sformatf("vec%0d_done_pulse", k), done, 1);
        adv();
        sample();
        chk($sformatf("vec%0d_done_clear", k), done, 0);
        chk($sformatf("vec%0d_done_count", k), n_done, 1);
        adv();
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    idx;
        bit    got;
        beat_t e;

        vecs[0] = '{col: {16'd9, 16'd0, 16'd7, 16'd3},
                    aval: {32'h44, 32'h33, 32'h22, 32'h11}, mask: 4'b1111,
                    raddr: {16'd9, 16'd0, 16'd7, 16'd3},
                    xval: {32'd90, 32'd0, 32'd70, 32'd30}};
        vecs[1] = '{col: {16'd8, 16'd7, 16'd6, 16'd5},
                    aval: {32'hA4, 32'hA3, 32'hA2, 32'hA1}, mask: 4'b0101,
                    raddr: {16'd0, 16'd7, 16'd0, 16'd5},
                    xval: {32'd0, 32'd70, 32'd0, 32'd50}};
        vecs[2] = '{col: {16'd4, 16'd3, 16'd2, 16'd1},
                    aval: {32'hB4, 32'hB3, 32'hB2, 32'hB1}, mask: 4'b0000,
                    raddr: 64'd0, xval: 128'd0};
        vecs[3] = '{col: {16'd400, 16'd300, 16'd200, 16'd100},
                    aval: {32'hDEAD_BEEF, 32'h3, 32'h2, 32'h1}, mask: 4'b1000,
                    raddr: {16'd400, 48'd0},
                    xval: {32'd4000, 96'd0}};
        vecs[4] = '{col: {16'd3, 16'd2, 16'd1, 16'd65535},
                    aval: {32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h7},
                    mask: 4'b1111,
                    raddr: {16'd3, 16'd2, 16'd1, 16'd65535},
                    xval: {32'd30, 32'd20, 32'd10, 32'd655350}};

        // Reset: handshakes and data outputs held at zero even with a beat offered.
        rst_n      = 1'b0;
        vr_arready = 1'b1;
        vr_rvalid  = 1'b0;
        vr_rdata   = '0;
        o_ready    = 1'b1;
        s_valid    = 1'b1;
        s_col      = vecs[0].col;
        s_aval     = vecs[0].aval;
        s_mask     = 4'hF;
        s_last     = 1'b1;
        #3;
        chk("rst_arvalid", vr_arvalid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_rready", vr_rready, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_raddr", vr_raddr, 0);
        chk("rst_xval", o_xval, 0);
        chk("rst_aval", o_aval, 0);
        s_valid = 1'b0;
        adv();
        adv();
        rst_n = 1'b1;
        adv();

        for (int k = 0; k < 5; k++) run_vec(k);

        // Credit limit: RAM silent, 10 beats offered, only 8 may issue.
        n_issued = 0;
        n_done   = 0;
        ram_hold = 1'b1;
        o_ready  = 1'b1;
        idx      = 0;
        for (int c = 0; c < 14; c++) begin
            drive_beat(idx, idx == 9);
            sample();
            if (s_valid && s_ready) idx++;
            adv();
        end
        chk("limit_issued", n_issued, 8);
        chk("limit_s_ready", s_ready, 0);
        chk("limit_arvalid", vr_arvalid, 0);
        ram_hold = 1'b0;
        ram_drive();
        drive_beat(idx, idx == 9);
        sample();
        chk("full_rvalid", vr_rvalid, 1);
        chk("full_rready", vr_rready, 1);
        chk("full_blocked", s_ready, 0);
        if (s_valid && s_ready) idx++;
        adv();
        drive_beat(idx, idx == 9);
        sample();
        chk("c7_s_ready", s_ready, 1);
        chk("c7_resp", vr_rvalid && vr_rready, 1);
        if (s_valid && s_ready) idx++;
        adv();
        drive_beat(idx, idx == 9);
        sample();
        chk("c7_hold", s_ready, 1);
        if (s_valid && s_ready) idx++;
        adv();
        s_valid = 1'b0;
        s_last  = 1'b0;
        idle(40);
        chk("limit_total_issued", n_issued, 10);
        chk("limit_done_count", n_done, 1);
        cmp_sb("limit");

        // Output back-pressure: o_ready low for 5 cycles once the first output is up.
        n_done  = 0;
        o_ready = 1'b0;
        idx     = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 3) drive_beat(20 + idx, idx == 2);
            else s_valid = 1'b0;
            sample();
            if (s_valid && s_ready) idx++;
            adv();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        got     = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            sample();
            if (o_valid) got = 1'b1;
            else adv();
        end
        chk("stall_o_valid", got, 1);
        e.aval = '0;
        e.xval = '0;
        if (exp_q.size() > 0) e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_valid", i), o_valid, 1);
            chk($sformatf("stall%0d_aval", i), o_aval, e.aval);
            chk($sformatf("stall%0d_xval", i), o_xval, e.xval);
            chk($sformatf("stall%0d_rready", i), vr_rready, 0);
            adv();
            if (i < 4) sample();
        end
        o_ready = 1'b1;
        idle(20);
        chk("stall_done_count", n_done, 1);
        cmp_sb("stall");

        // Reset with 3 reads outstanding, then a clean one-beat block.
        ram_hold = 1'b1;
        idx      = 0;
        for (int c = 0; c < 3; c++) begin
            drive_beat(40 + idx, 1'b0);
            sample();
            if (s_valid && s_ready) idx++;
            adv();
        end
        chk("mid_issued", idx, 3);
        drive_beat(43, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", vr_arvalid, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_rready", vr_rready, 0);
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_raddr", vr_raddr, 0);
        chk("mid_rst_xval", o_xval, 0);
        req_q.delete();
        exp_q.delete();
        out_q.delete();
        s_valid  = 1'b0;
        ram_hold = 1'b0;
        vr_rvalid = 1'b0;
        adv();
        adv();
        rst_n = 1'b1;
        adv();
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spmv_x_fetch.md
SPMV_X_FETCH -- requirements
Module: spmv_x_fetch

Interface
REQ-001 Parameter PARALLELISM, default 4: lanes per beat; power of 2.
REQ-002 Parameter DATA_WIDTH, default 32: matrix/vector element width.
REQ-003 Parameter ADDR_WIDTH, default 16: column index width.
REQ-004 Parameter MAX_OUTSTANDING, default 8: read-credit limit; also matrix-value side FIFO depth.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 s_valid / s_ready  in / out  1 / 1  input beat handshake.
REQ-008 s_col  in  PARALLELISM*ADDR_WIDTH  per-lane column index.
REQ-009 s_aval  in  PARALLELISM*DATA_WIDTH  per-lane matrix value.
REQ-010 s_mask  in  PARALLELISM  lane-active bits.
REQ-011 s_last  in  1  final beat of the row block.
REQ-012 vr_arvalid / vr_arready  out / in  1 / 1  vector-RAM read-request handshake.
REQ-013 vr_raddr  out  PARALLELISM*ADDR_WIDTH  read addresses.
REQ-014 vr_rvalid / vr_rready  in / out  1 / 1  vector-RAM response handshake.
REQ-015 vr_rdata  in  PARALLELISM*DATA_WIDTH  returned x values, in request order.
REQ-016 o_valid / o_ready  out / in  1 / 1  paired output handshake.
REQ-017 o_aval, o_xval  out  PARALLELISM*DATA_WIDTH each  matrix values, x values.
REQ-018 o_mask, o_last  out  PARALLELISM, 1  forwarded mask and last.
REQ-019 done  out  1  one-cycle pulse at end of block.

Function
REQ-020 States IDLE, RUN, DRAIN. IDLE->RUN on first accepted s beat. RUN->DRAIN when beat with s_last issues. DRAIN->IDLE when outstanding=0 and output register empty; done pulses that cycle.
REQ-021 Issue when s_valid, credits<MAX_OUTSTANDING, side FIFO not full, state!=DRAIN: vr_arvalid=1; s_ready=vr_arready under same conditions; beat consumed on vr_arvalid&&vr_arready.
REQ-022 vr_raddr lane = s_col lane if mask bit set, else 0; vr_arvalid does not depend on vr_arready.
REQ-023 On issue, {s_aval, s_mask, s_last} pushed into side FIFO same cycle.
REQ-024 Credit counter +1 on issue, -1 on response acceptance; both in one cycle leaves it unchanged; never exceeds MAX_OUTSTANDING.
REQ-025 vr_rready=1 when output register empty or o_ready=1; on vr_rvalid&&vr_rready pop side FIFO, load output register next cycle.
REQ-026 Output register: o_xval lane = vr_rdata lane if mask set else 0; o_aval, o_mask, o_last from FIFO head; o_valid held until o_ready; contents stable while o_valid&&!o_ready.
REQ-027 Latency: issue-to-output minimum 1 cycle after vr_rvalid; full throughput one beat/cycle with zero-latency RAM and o_ready=1.
REQ-028 Response arriving with side FIFO empty: ignored, sticky error flag internal, vr_rready still 1; assertion fires in simulation.
REQ-029 Beat with s_mask=0: still issued and paired (preserves ordering).

Reset
REQ-030 During rst_n=0: state IDLE, credits 0, side FIFO empty, o_valid 0, vr_arvalid 0, s_ready 0, vr_rready 0, done 0, data outputs 0.
REQ-031 Reset mid-operation discards all in-flight beats; late responses after release are treated per REQ-028.

Configuration
REQ-032 Macro SPMV_X_FETCH_STATS_EN: when defined, adds outputs stat_beats (32b, issued beats) and stat_stall (32b, cycles s_valid&&!s_ready), both reset to 0, saturating; when undefined, ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-033 P=4, one beat cols {3,7,0,9} mask 1111 last=1, RAM returns {30,70,0,90} after 2 cycles -> o_xval {30,70,0,90}, o_aval matches input, o_last=1, done pulses once.
REQ-034 mask 0101 cols {5,6,7,8} -> vr_raddr {5,0,7,0}; o_xval lanes 1,3 are 0.
REQ-035 vr_rvalid held 0, 10 beats offered, MAX_OUTSTANDING=8 -> exactly 8 issued, s_ready=0 until first response.
REQ-036 o_ready=0 for 5 cycles with output valid -> o_* stable, vr_rready=0, no beat lost or duplicated after release.
REQ-037 Simultaneous issue and response at credits=8 -> issue blocked that cycle; at credits=7 both occur, credits stay 7.
REQ-038 rst_n pulled low with 3 outstanding -> all outputs to reset values immediately; following clean 1-beat block completes correctly.
